// File: rtl/md_pkg.sv
// Shared definitions for the multi-cycle HI/LO multiply/divide unit.
// The ALU codes are also used by the ALU controller.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;

  localparam logic [3:0] ALU_MULT = 4'b1110;
  localparam logic [3:0] ALU_DIV  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_iter_datapath.sv
// Shared shift datapath: shift-add multiply and restoring divide on one
// 2*WIDTH accumulator, plus the sign fix-up negators for the final result.
module md_iter_datapath
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_div,
  input  logic             step_mul,
  input  logic             step_div,
  input  logic             is_div,
  input  logic             sign_q,
  input  logic             sign_r,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [WIDTH:0]     add_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   diff_s;
  logic               fits_s;

  // The carry out of add_s becomes the top bit of the right-shifted 65-bit value.
  // In divide, rem/quo live in acc_r upper/lower halves; the shifted remainder
  // is WIDTH+1 bits, but when it is non-negative after subtracting, the result fits in WIDTH.
  always_comb begin
    add_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    mul_next_s = {add_s, acc_r[WIDTH-1:1]};
    fits_s     = (acc_r[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_r});
    diff_s     = acc_r[2*WIDTH-2:WIDTH-1] - opnd_r;
    if (fits_s) begin
      div_next_s = {diff_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end
    prod_fix_s = sign_q ? -acc_r : acc_r;
    if (is_div) begin
      res_lo = sign_q ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
      res_hi = sign_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = prod_fix_s[WIDTH-1:0];
      res_hi = prod_fix_s[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r  <= '0;
      opnd_r <= '0;
    end else if (load) begin
      acc_r  <= {{WIDTH{1'b0}}, (load_div ? a_mag : b_mag)};
      opnd_r <= load_div ? b_mag : a_mag;
    end else if (step_mul) begin
      acc_r <= mul_next_s;
    end else if (step_div) begin
      acc_r <= div_next_s;
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; FSM, iteration counter,
// HI/LO registers and the pipeline stall request.
module mult_div_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [3:0]       i_ALUCtrlE,
  input  logic             i_StartE,
  input  logic             i_SignedE,
  input  logic [WIDTH-1:0] i_SrcAE,
  input  logic [WIDTH-1:0] i_SrcBE,
  input  logic             i_HiLoRdD,
  input  logic             i_WrHi,
  input  logic             i_WrLo,
  input  logic [WIDTH-1:0] i_WrData,
  input  logic             i_Flush,
  output logic             o_Busy,
  output logic             o_Stall,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_HI,
  output logic [WIDTH-1:0] o_LO
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_e        state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r, dividend_r;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, res_hi_s, res_lo_s;
  logic             busy_r, done_r, sign_q_r, sign_r_r, dz_r, op_div_r;
  logic             md_code_s, accept_s, sa_s, sb_s, commit_s, div_zero_s, iterating_s;

  assign md_code_s   = i_StartE & (i_ALUCtrlE[3:1] == ALU_MULT[3:1]);
  assign accept_s    = (state_r == S_IDLE) & md_code_s & ~i_Flush;
  assign sa_s        = i_SignedE & i_SrcAE[WIDTH-1];
  assign sb_s        = i_SignedE & i_SrcBE[WIDTH-1];
  assign a_mag_s     = sa_s ? -i_SrcAE : i_SrcAE;
  assign b_mag_s     = sb_s ? -i_SrcBE : i_SrcBE;
  assign div_zero_s  = (i_ALUCtrlE == ALU_DIV) & (i_SrcBE == {WIDTH{1'b0}});
  assign commit_s    = (state_r == S_FIX) & ~i_Flush;
  assign iterating_s = (state_r == S_MUL) | (state_r == S_DIV);

  assign o_Busy  = busy_r;
  assign o_Done  = done_r;
  assign o_HI    = hi_r;
  assign o_LO    = lo_r;
  assign o_Stall = busy_r & (md_code_s | i_HiLoRdD | i_WrHi | i_WrLo);

  always_comb begin
    next_state_s = state_r;
    if (i_Flush) begin
      next_state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            if (i_ALUCtrlE == ALU_DIV) begin
              next_state_s = div_zero_s ? S_FIX : S_DIV;
            end else begin
              next_state_s = S_MUL;
            end
          end else begin
            next_state_s = S_IDLE;
          end
        end
        S_MUL:   next_state_s = (cnt_r == LAST) ? S_FIX : S_MUL;
        S_DIV:   next_state_s = (cnt_r == LAST) ? S_FIX : S_DIV;
        S_FIX:   next_state_s = S_IDLE;
        default: next_state_s = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != S_IDLE);
      done_r  <= commit_s;
      cnt_r   <= (iterating_s && next_state_s == state_r) ? cnt_r + CNT_W'(1) : '0;
    end
  end

  // Operation context captured once at accept; operands may change afterwards.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      sign_q_r   <= 1'b0;
      sign_r_r   <= 1'b0;
      dz_r       <= 1'b0;
      op_div_r   <= 1'b0;
      dividend_r <= '0;
    end else if (accept_s) begin
      sign_q_r   <= sa_s ^ sb_s;
      sign_r_r   <= sa_s;
      dz_r       <= div_zero_s;
      op_div_r   <= i_ALUCtrlE[0];
      dividend_r <= i_SrcAE;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (commit_s) begin
      if (dz_r) begin
        hi_r <= dividend_r;
        lo_r <= {WIDTH{1'b1}};
      end else begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end
    end else if (!busy_r) begin
      if (i_WrHi) begin
        hi_r <= i_WrData;
      end
      if (i_WrLo) begin
        lo_r <= i_WrData;
      end
    end
  end

  md_iter_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk     (i_CLK),
    .rst     (i_RST),
    .load    (accept_s),
    .load_div(i_ALUCtrlE[0]),
    .step_mul(state_r == S_MUL),
    .step_div(state_r == S_DIV),
    .is_div  (op_div_r),
    .sign_q  (sign_q_r),
    .sign_r  (sign_r_r),
    .a_mag   (a_mag_s),
    .b_mag   (b_mag_s),
    .res_hi  (res_hi_s),
    .res_lo  (res_lo_s)
  );

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed testbench for mult_div_sequencer with hand-computed HI/LO results,
// latency, stall, flush and reset checks.
module tb_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alu_ctrl;
  logic        start, sgn, hilo_rd, wr_hi, wr_lo, flush;
  logic [31:0] src_a, src_b, wr_data;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mult_div_sequencer dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_ALUCtrlE(alu_ctrl),
    .i_StartE  (start),
    .i_SignedE (sgn),
    .i_SrcAE   (src_a),
    .i_SrcBE   (src_b),
    .i_HiLoRdD (hilo_rd),
    .i_WrHi    (wr_hi),
    .i_WrLo    (wr_lo),
    .i_WrData  (wr_data),
    .i_Flush   (flush),
    .o_Busy    (busy),
    .o_Stall   (stall),
    .o_Done    (done),
    .o_HI      (hi),
    .o_LO      (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Counts samples (each #1 after a rising edge) with busy high; bounded.
  task automatic wait_idle(output int nbusy);
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 200) begin
      nbusy++;
      @(posedge clk);
      #1;
    end
  endtask

  // Presents an op for one accept edge, then scrambles the operands.
  task automatic issue(input logic [3:0] ctrl, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_ctrl = ctrl; sgn = s; src_a = a; src_b = b; start = 1'b1;
    #1;
    check("stall_on_accept", stall, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0; sgn = ~s; src_a = 32'hDEAD_BEEF; src_b = 32'h0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_busy);
    int n;
    issue(ctrl, s, a, b);
    wait_idle(n);
    check({tag, "_busy_cycles"}, n, exp_busy);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; alu_ctrl = 4'b0000; start = 1'b0; sgn = 1'b0; hilo_rd = 1'b0;
    wr_hi = 1'b0; wr_lo = 1'b0; flush = 1'b0; src_a = 32'h0; src_b = 32'h0; wr_data = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    run_op("multu_max", 4'b1110, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("mult_m7x6", 4'b1110, 1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 33);
    run_op("div_m7d2",  4'b1111, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu_100d7", 4'b1111, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("div_7dm2",  4'b1111, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_op("div_zero",  4'b1111, 1'b1, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1);
    run_op("div_ovf",   4'b1111, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    run_op("divu_big",  4'b1111, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33);

    // MTHI on the accept cycle lands first, then the commit overwrites it.
    @(negedge clk);
    alu_ctrl = 4'b1111; sgn = 1'b0; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    wr_hi = 1'b1; wr_data = 32'h55;
    @(posedge clk);
    #1;
    start = 1'b0; wr_hi = 1'b0;
    check("mthi_accept_hi", hi, 32'h55);
    wait_idle(n);
    check("mthi_accept_final_hi", hi, 32'd2);
    check("mthi_accept_final_lo", lo, 32'd14);

    // MFHI plus a new DIV arriving mid-MUL stall until the unit is idle.
    issue(4'b1110, 1'b0, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    hilo_rd = 1'b1; alu_ctrl = 4'b1111; sgn = 1'b0; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", n, 29);
    check("stall_busy_low", busy, 1'b0);
    check("stall_mul_hi", hi, 32'd0);
    check("stall_mul_lo", lo, 32'd12);
    hilo_rd = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; src_a = 32'h0; src_b = 32'h0;
    check("stalled_div_accepted", busy, 1'b1);
    wait_idle(n);
    check("stalled_div_busy", n, 33);
    check("stalled_div_hi", hi, 32'd2);
    check("stalled_div_lo", lo, 32'd14);

    // Flush mid-MUL: HI/LO untouched, no done; MTLO while busy is ignored.
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'hAA;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'hBB;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mthi_hi", hi, 32'hAA);
    check("mtlo_lo", lo, 32'hBB);
    issue(4'b1110, 1'b0, 32'd3, 32'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'h99;
    @(negedge clk);
    wr_lo = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    n = 0;
    if (done === 1'b1) n++;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n++;
    end
    check("flush_no_done", n, 0);
    check("flush_hi", hi, 32'hAA);
    check("flush_lo", lo, 32'hBB);

    // Flush wins over a same-cycle accept.
    @(negedge clk);
    flush = 1'b1; start = 1'b1; alu_ctrl = 4'b1110; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk);
    #1;
    flush = 1'b0; start = 1'b0;
    check("flush_vs_accept_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    check("flush_vs_accept_idle", busy, 1'b0);

    // Asynchronous reset mid-DIV clears HI/LO without waiting for an edge.
    run_op("pre_rst", 4'b1111, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    issue(4'b1111, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 4'b1110, 1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 33);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Multi-cycle HI/LO unit beside the single-cycle ALU in the EX stage.
- Accepts MULT/DIV operations (ALU control codes 4'b1110 / 4'b1111) and runs a 32-iteration shift-add multiply or restoring divide on one shared 64-bit shift datapath.
- Owns the HI/LO registers.
- Raises a pipeline stall while any later HI/LO consumer or producer would collide with an in-flight operation.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.
- CNT_W, 5, iteration counter width; must be at least clog2(WIDTH).

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_ALUCtrlE  in  4  ALU control code from the EX stage; only 1110 and 1111 start an operation.
- i_StartE  in  1  valid, unflushed instruction in EX carrying i_ALUCtrlE.
- i_SignedE  in  1  1 = MULT/DIV, 0 = MULTU/DIVU.
- i_SrcAE  in  WIDTH  multiplicand / dividend.
- i_SrcBE  in  WIDTH  multiplier / divisor.
- i_HiLoRdD  in  1  MFHI/MFLO present in decode.
- i_WrHi  in  1  MTHI write request.
- i_WrLo  in  1  MTLO write request.
- i_WrData  in  WIDTH  MTHI/MTLO data.
- i_Flush  in  1  abort any in-flight operation.
- o_Busy  out  1  registered; high while state != IDLE.
- o_Stall  out  1  combinational pipeline stall request.
- o_Done  out  1  one-cycle pulse after HI/LO commit.
- o_HI  out  WIDTH  HI register.
- o_LO  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous): state IDLE, counter 0, internal shift registers 0, o_HI = 0, o_LO = 0, o_Busy = 0, o_Done = 0.
- State set: IDLE, MUL, DIV, FIX.
- Accept condition (IDLE only): i_StartE & i_ALUCtrlE[3:1] == 3'b111.
  - On accept, latch magnitudes of both operands (two's-complement abs when i_SignedE, raw otherwise).
  - Record sign_q = sA ^ sB and sign_r = sA.
  - Go to MUL (code 1110) or DIV (code 1111).
  - Divide by zero: go directly to FIX with flag dz set.
- MUL: each cycle, if acc[0] then upper half += multiplicand, then shift the 65-bit {carry, acc} right by 1. After WIDTH cycles (counter == WIDTH-1) go to FIX.
- DIV (restoring): each cycle, shift {rem, quo} left by 1, trial-subtract the divisor from rem, keep the result and set quo[0] = 1 if non-negative. After WIDTH cycles go to FIX.
- FIX: commit results, then return to IDLE and pulse o_Done for the next cycle.
  - MUL: {HI, LO} = sign_q ? -product : product (64-bit negate).
  - DIV: LO = sign_q ? -quo : quo; HI = sign_r ? -rem : rem.
  - dz: LO = 32'hFFFFFFFF, HI = i_SrcAE as latched (raw dividend).
- Latency: accept at edge k; HI/LO updated at edge k+WIDTH+1 (k+33); o_Busy high for cycles k+1 through k+33; o_Done high in cycle k+34. Divide by zero: commit at edge k+1.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no trap.
- Stall: o_Stall = o_Busy & (i_StartE & MD code | i_HiLoRdD | i_WrHi | i_WrLo). No stall on the accept cycle itself.
- MTHI/MTLO: when not busy, HI/LO are written at the edge. An i_WrHi/i_WrLo arriving in the same cycle as an accept is applied first and then overwritten by the commit.
- Flush: i_Flush in any state returns to IDLE next edge with HI/LO unchanged and no o_Done. Flush takes priority over a same-cycle accept.
- Operand stability: operands are sampled only at accept; i_SrcAE/i_SrcBE may change afterwards.

Decomposition:
- Package md_pkg holds:
  - the state enum;
  - the ALU codes MULT = 4'b1110 and DIV = 4'b1111, shared with the ALU controller;
  - WIDTH defaults.
- One sub-module, md_iter_datapath, holds the 65-bit shift accumulator, the adder/subtractor and the sign fix-up negators. The top level keeps the FSM, counter, HI/LO and stall logic.

Test Plan:
- Unsigned MULT 0xFFFFFFFF × 0xFFFFFFFF, i_SignedE = 0 -> at edge k+33 HI = 0xFFFFFFFE, LO = 0x00000001; o_Done one cycle; o_Busy high 33 cycles.
- Signed MULT -7 × 6 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFD6.
- Signed DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then DIVU 100 / 7 -> LO = 14, HI = 2.
- Divide by zero, DIV 0x1234 / 0 -> commit at edge k+1: LO = 0xFFFFFFFF, HI = 0x1234.
- MFHI asserted at cycle k+5 during MUL -> o_Stall = 1 through cycle k+33 and 0 at k+34. A new DIV issued mid-operation is also stalled, then accepted once IDLE.
- i_Flush at k+10 during MUL 3 × 4 with prior HI/LO = 0xAA/0xBB -> IDLE at k+11, HI/LO stay 0xAA/0xBB, no o_Done. An i_RST pulse mid-DIV clears HI/LO to 0 immediately.
